// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt front-end: line count, fixed line
// assignments and the per-line vector type.
package irq_pkg;

   localparam int unsigned NUM_IRQ      = 32;

   // Fixed line assignments
   localparam int unsigned IRQ_TIMER    = 0;
   localparam int unsigned IRQ_EBREAK   = 1;
   localparam int unsigned IRQ_BUSERROR = 2;

   typedef logic [NUM_IRQ-1:0] irq_vec_t;

endpackage : irq_pkg

// File: rtl/irq_sync.sv
// Single-bit synchronizer: a SYNC_STAGES-deep flop chain that brings one
// asynchronous interrupt source into the clk domain. Resets to 0, so a line
// held high across reset release produces exactly one rising edge downstream.
module irq_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_chain;

   // Shift the raw input through the chain; the oldest stage is the output
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[SYNC_STAGES-1];

endmodule : irq_sync

// File: rtl/irq_front.sv
// Interrupt front-end: synchronizes 32 raw sources, applies per-line masking
// and edge/level latching, holds pending bits until end-of-interrupt, flags
// overruns, and runs the one-shot countdown timer that owns line 0.
module irq_front
   import irq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES      = 2,
   parameter logic [31:0] MASKED_IRQ       = 32'h0000_0000,
   parameter logic [31:0] LATCHED_IRQ      = 32'hffff_ffff,
   parameter logic [31:0] EDGE_IRQ         = 32'hffff_ffff,
   parameter bit          ENABLE_IRQ_TIMER = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] irq_in,
   input  logic [31:0] eoi,
   input  logic        timer_wr,
   input  logic [31:0] timer_wdata,
   output logic [31:0] timer_rdata,
   output logic [31:0] irq,
   output logic        irq_any,
   output logic [31:0] irq_overrun
);

   // The timer line always behaves as a latched line, whatever LATCHED_IRQ says,
   // and its external input is ignored.
   localparam irq_vec_t TIMER_MASK = irq_vec_t'(ENABLE_IRQ_TIMER) << IRQ_TIMER;
   localparam irq_vec_t LATCH_EFF  = irq_vec_t'(LATCHED_IRQ) | TIMER_MASK;

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_depth
         $error("irq_front: SYNC_STAGES must be 2 or 3");
      end
   endgenerate

   irq_vec_t    w_sync;
   irq_vec_t    r_prev;
   irq_vec_t    w_rise;
   irq_vec_t    w_set;
   irq_vec_t    w_ovr_evt;
   irq_vec_t    w_pending_nxt;
   irq_vec_t    w_overrun_nxt;
   irq_vec_t    r_pending;
   irq_vec_t    r_overrun;
   logic [31:0] r_timer;
   logic [31:0] w_timer_nxt;
   logic        w_timer_expire;

   // One synchronizer per external line
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
         irq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_sync (
            .clk    (clk),
            .resetn (resetn),
            .i_d    (irq_in[gi]),
            .o_q    (w_sync[gi])
         );
      end
   endgenerate

   // Timer next value: a write wins and never expires; otherwise count down
   // to 0 and stop, flagging expiry on the 1->0 step
   always_comb begin
      w_timer_nxt    = r_timer;
      w_timer_expire = 1'b0;
      if (timer_wr) begin
         w_timer_nxt = timer_wdata;
      end else if (r_timer != '0) begin
         w_timer_nxt    = r_timer - 32'd1;
         w_timer_expire = (r_timer == 32'd1);
      end
   end

   // Per-line set condition: masked lines never set, edge lines set on a
   // synchronized rise, level lines set while high, line 0 on timer expiry
   always_comb begin
      w_rise = w_sync & ~r_prev;
      w_set  = ~irq_vec_t'(MASKED_IRQ) &
               ((irq_vec_t'(EDGE_IRQ) & w_rise) | (~irq_vec_t'(EDGE_IRQ) & w_sync));
      if (ENABLE_IRQ_TIMER) begin
         w_set[IRQ_TIMER] = ~MASKED_IRQ[IRQ_TIMER] & w_timer_expire;
      end
   end

   // Pending/overrun next state: latched lines hold until eoi with set taking
   // precedence; non-latched lines follow the synchronized level and never
   // report overruns
   always_comb begin
      w_ovr_evt     = LATCH_EFF & w_set & r_pending & ~eoi;
      w_pending_nxt = (LATCH_EFF & (w_set | (r_pending & ~eoi))) |
                      (~LATCH_EFF & w_sync & ~irq_vec_t'(MASKED_IRQ));
      w_overrun_nxt = LATCH_EFF & (w_ovr_evt | (r_overrun & ~eoi));
   end

   // Edge-detect history of the synchronized lines
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_prev <= '0;
      end else begin
         r_prev <= w_sync;
      end
   end

   // Pending vector and sticky overrun flags
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pending <= '0;
         r_overrun <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   // Countdown timer register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_timer <= '0;
      end else begin
         r_timer <= w_timer_nxt;
      end
   end

   assign irq         = r_pending;
   assign irq_any     = |r_pending;
   assign irq_overrun = r_overrun;
   assign timer_rdata = r_timer;

endmodule : irq_front
